// File: rtl/bcd_ctr_n.sv
// bcd_ctr_n: DIGITS-wide BCD up/down counter with a programmable terminal value,
// synchronous load, wrap-or-saturate behaviour, a combinational carry/borrow
// flag and a registered one-cycle terminal-event pulse.
module bcd_ctr_n #(
    parameter int DIGITS = 4,
    parameter int WRAP   = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                en,
    input  logic                ld,
    input  logic                up,
    input  logic [4*DIGITS-1:0] d,
    input  logic [4*DIGITS-1:0] lim,
    output logic [4*DIGITS-1:0] q,
    output logic                co,
    output logic                tc
);

    localparam int W = 4 * DIGITS;

    // Force every digit into 0..9 so later arithmetic only sees legal BCD.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Add one with decimal carry ripple from the least significant digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Subtract one with decimal borrow ripple from the least significant digit.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    logic [W-1:0] q_r;
    logic         tc_r;
    logic [W-1:0] d_c_s;
    logic [W-1:0] lim_c_s;
    logic [W-1:0] ld_val_s;
    logic         at_top_s;
    logic         at_zero_s;
    logic [W-1:0] q_next_s;
    logic         tc_next_s;

    // With all digits legal, packed BCD orders exactly like the decimal value,
    // so plain unsigned compares on the vectors are decimal compares.
    assign d_c_s     = clamp_bcd(d);
    assign lim_c_s   = clamp_bcd(lim);
    assign ld_val_s  = (d_c_s < lim_c_s) ? d_c_s : lim_c_s;
    assign at_top_s  = (q_r >= lim_c_s);
    assign at_zero_s = (q_r == {W{1'b0}});

    // Carry/borrow flag follows direction and current count, regardless of en.
    always_comb begin
        co = 1'b0;
        if (up) begin
            co = at_top_s;
        end else begin
            co = at_zero_s;
        end
    end

    // Next-count selection: load beats count; terminal events flag tc.
    always_comb begin
        q_next_s  = q_r;
        tc_next_s = 1'b0;
        if (en && ld) begin
            q_next_s = ld_val_s;
        end else if (en) begin
            if (up) begin
                if (at_top_s) begin
                    q_next_s  = (WRAP != 0) ? {W{1'b0}} : lim_c_s;
                    tc_next_s = 1'b1;
                end else begin
                    q_next_s = bcd_inc(q_r);
                end
            end else begin
                if (at_zero_s) begin
                    q_next_s  = (WRAP != 0) ? lim_c_s : {W{1'b0}};
                    tc_next_s = 1'b1;
                end else begin
                    q_next_s = bcd_dec(q_r);
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Count and pulse registers; clr overrides everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r  <= {W{1'b0}};
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_next_s;
            tc_r <= tc_next_s;
        end
    end

    assign q  = q_r;
    assign tc = tc_r;

endmodule

// File: tb/tb_bcd_ctr_n.sv
// Scoreboard bench for bcd_ctr_n: a wrapping and a saturating instance share
// stimulus; an integer-arithmetic model predicts co, q and tc per cycle.
module tb_bcd_ctr_n;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en  = 1'b0;
    logic        ld  = 1'b0;
    logic        up  = 1'b0;
    logic [15:0] d   = 16'h0000;
    logic [15:0] lim = 16'h0000;
    logic [15:0] q1, q0;
    logic        co1, co0, tc1, tc0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        chk_co;
        logic        co1, co0;
        logic [15:0] q1, q0;
        logic        tc1, tc0;
    } exp_t;

    exp_t sb[$];

    int m1 = 0;
    int m0 = 0;

    bcd_ctr_n #(.DIGITS(4), .WRAP(1)) dut_wrap (
        .clk(clk), .clr(clr), .en(en), .ld(ld), .up(up),
        .d(d), .lim(lim), .q(q1), .co(co1), .tc(tc1)
    );

    bcd_ctr_n #(.DIGITS(4), .WRAP(0)) dut_sat (
        .clk(clk), .clr(clr), .en(en), .ld(ld), .up(up),
        .d(d), .lim(lim), .q(q0), .co(co0), .tc(tc0)
    );

    always #5 clk = ~clk;

    // Decimal value of a BCD word, digits above 9 read as 9.
    function automatic int bcd2int(input logic [15:0] v);
        int r;
        int dg;
        int p;
        r = 0;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            dg = int'(v[4*i +: 4]);
            if (dg > 9) dg = 9;
            r = r + dg * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        int          t;
        r = 16'h0000;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int model_next(input int m, input bit wrap, input int lv,
                                      input int dv, input bit e, input bit l, input bit u,
                                      output bit t);
        t = 1'b0;
        if (e && l) return (dv < lv) ? dv : lv;
        if (!e) return m;
        if (u) begin
            if (m >= lv) begin t = 1'b1; return wrap ? 0 : lv; end
            return m + 1;
        end
        if (m == 0) begin t = 1'b1; return wrap ? lv : 0; end
        return m - 1;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the expected response goes to the scoreboard.
    task automatic step(input bit c, input bit e, input bit l, input bit u,
                        input logic [15:0] dv, input logic [15:0] lv, input bit chk_co);
        exp_t x;
        int   li, di;
        bit   t1, t0;
        @(negedge clk);
        clr = c; en = e; ld = l; up = u; d = dv; lim = lv;
        li = bcd2int(lv);
        di = bcd2int(dv);
        x.chk_co = chk_co;
        x.co1 = u ? (m1 >= li) : (m1 == 0);
        x.co0 = u ? (m0 >= li) : (m0 == 0);
        if (c) begin
            m1 = 0; m0 = 0; t1 = 1'b0; t0 = 1'b0;
        end else begin
            m1 = model_next(m1, 1'b1, li, di, e, l, u, t1);
            m0 = model_next(m0, 1'b0, li, di, e, l, u, t0);
        end
        x.q1 = int2bcd(m1); x.q0 = int2bcd(m0);
        x.tc1 = t1; x.tc0 = t0;
        sb.push_back(x);
    endtask

    // Monitor: co is checked just before the edge, q/tc just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_co) begin
                    check("co_wrap", {15'd0, co1}, {15'd0, e.co1});
                    check("co_sat",  {15'd0, co0}, {15'd0, e.co0});
                end
                @(posedge clk);
                #1;
                check("q_wrap",  q1, e.q1);
                check("q_sat",   q0, e.q0);
                check("tc_wrap", {15'd0, tc1}, {15'd0, e.tc1});
                check("tc_sat",  {15'd0, tc0}, {15'd0, e.tc0});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic [15:0] rl;
        logic [15:0] rd;
        // clr with load pending, then first count
        step(1, 1, 1, 1, 16'h1234, 16'h9999, 0);
        step(0, 1, 0, 1, 16'h1234, 16'h9999, 1);
        // decimal carry and borrow across digits
        step(0, 1, 1, 1, 16'h0999, 16'h9999, 1);
        step(0, 1, 0, 1, 16'h0000, 16'h9999, 1);
        step(0, 1, 1, 0, 16'h1000, 16'h9999, 1);
        step(0, 1, 0, 0, 16'h0000, 16'h9999, 1);
        // terminal count up, then idle so tc drops
        step(0, 1, 1, 1, 16'h0059, 16'h0059, 1);
        step(0, 1, 0, 1, 16'h0000, 16'h0059, 1);
        step(0, 0, 0, 1, 16'h0000, 16'h0059, 1);
        // terminal count down from zero
        step(0, 1, 1, 0, 16'h0000, 16'h0059, 1);
        step(0, 1, 0, 0, 16'h0000, 16'h0059, 1);
        step(0, 0, 0, 0, 16'h0000, 16'h0059, 1);
        // clamped load limited by lim, then disabled load ignored
        step(0, 1, 1, 1, 16'h0A7F, 16'h0500, 1);
        step(0, 0, 1, 1, 16'h0100, 16'h0500, 1);
        // lim lowered below q
        step(0, 1, 1, 1, 16'h0300, 16'h9999, 1);
        step(0, 1, 0, 1, 16'h0000, 16'h0200, 1);
        step(0, 1, 0, 1, 16'h0000, 16'h0200, 1);
        // lim of zero pins the count
        for (int i = 0; i < 6; i++) step(0, 1, 0, i[0], 16'h0000, 16'h0000, 1);
        // clamped all-F lim behaves as 9999
        step(0, 1, 1, 1, 16'h9998, 16'hFFFF, 1);
        step(0, 1, 0, 1, 16'h0000, 16'hFFFF, 1);
        step(0, 1, 0, 1, 16'h0000, 16'hFFFF, 1);
        // mid-run clr aborts state
        step(1, 1, 0, 1, 16'h0000, 16'hFFFF, 1);
        // randomized traffic
        rl = 16'h0120;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(31) == 0) begin
                case ($urandom_range(3))
                    0: rl = 16'h0000;
                    1: rl = 16'($urandom);
                    default: rl = int2bcd(int'($urandom_range(60)));
                endcase
            end
            rd = ($urandom_range(1) == 0) ? 16'($urandom) : int2bcd(int'($urandom_range(80)));
            step($urandom_range(63) == 0, $urandom_range(3) != 0,
                 $urandom_range(7) == 0, $urandom_range(2) != 0, rd, rl, 1);
        end
        @(negedge clk);
        en = 1'b0; ld = 1'b0; clr = 1'b0;
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
